id_stage: RTL and testbench

- Registered, parametrised instruction-decode pipeline stage for the accumulator CPU.
- Sits between instruction fetch and the execute/register-file stage.
- Accepts instruction words over a valid/ready handshake and splits each word into opcode and register address.
- Produces one-hot-style unit enables, and supports the two-word LDI (load-immediate) instruction through a small state machine.
- Adds flush and backpressure, which the purely combinational decoder it replaces lacks.

---
 rtl/id_pkg.sv | 40 ++++
 rtl/id_stage_if.sv | 50 +++++
 rtl/id_opdec.sv | 35 +++
 rtl/id_stage.sv | 201 ++++++++++++++++++++
 tb/tb_id_stage.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg
// Shared definitions for the accumulator-CPU instruction-decode stage:
//   - default word / register-address widths
//   - opcode values (10..15 and anything wider are undefined)
//   - decode-stage state encoding
//   - the flag bundle produced by the opcode decoder
// ---------------------------------------------------------------------------
package id_pkg;

    localparam int DEF_INSTR_W    = 8;
    localparam int DEF_REG_ADDR_W = 4;

    localparam int OP_NOP = 0;
    localparam int OP_LD  = 1;
    localparam int OP_ST  = 2;
    localparam int OP_ADD = 3;
    localparam int OP_SUB = 4;
    localparam int OP_AND = 5;
    localparam int OP_OR  = 6;
    localparam int OP_XOR = 7;
    localparam int OP_NOT = 8;
    localparam int OP_LDI = 9;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_IMM = 1'b1
    } state_t;

    // Unit enables for one opcode; legal=0 marks an undefined opcode.
    typedef struct packed {
        logic st;
        logic ld;
        logic cy;
        logic acc;
        logic imm_sel;
        logic legal;
    } dec_t;

endpackage

// File: rtl/id_stage_if.sv
// ---------------------------------------------------------------------------
// id_stage_if
// Fetch-side and execute-side handshake bundle of the decode stage.
//   master : environment side (drives flush, in_valid, in_instr, out_ready)
//   slave  : decode stage side (drives in_ready and all out_* signals)
// The sticky illegal flag exists only when ID_ILLEGAL_TRAP_EN is defined.
// ---------------------------------------------------------------------------
interface id_stage_if #(
    parameter int INSTR_W    = 8,
    parameter int REG_ADDR_W = 4
);
    localparam int OPCODE_W = INSTR_W - REG_ADDR_W;

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [INSTR_W-1:0]    in_instr;
    logic                  out_valid;
    logic                  out_ready;
    logic [OPCODE_W-1:0]   out_opcode;
    logic [REG_ADDR_W-1:0] out_reg_addr;
    logic [INSTR_W-1:0]    out_imm;
    logic                  out_st_ce;
    logic                  out_ld_ce;
    logic                  out_cy_ce;
    logic                  out_acc_ce;
    logic                  out_imm_sel;
`ifdef ID_ILLEGAL_TRAP_EN
    logic                  illegal;
`endif

    modport master (
        output flush, in_valid, in_instr, out_ready,
`ifdef ID_ILLEGAL_TRAP_EN
        input  illegal,
`endif
        input  in_ready, out_valid, out_opcode, out_reg_addr, out_imm,
               out_st_ce, out_ld_ce, out_cy_ce, out_acc_ce, out_imm_sel
    );

    modport slave (
        input  flush, in_valid, in_instr, out_ready,
`ifdef ID_ILLEGAL_TRAP_EN
        output illegal,
`endif
        output in_ready, out_valid, out_opcode, out_reg_addr, out_imm,
               out_st_ce, out_ld_ce, out_cy_ce, out_acc_ce, out_imm_sel
    );

endinterface

// File: rtl/id_opdec.sv
// ---------------------------------------------------------------------------
// id_opdec
// Combinational opcode decoder feeding the decode-stage output register.
//   opcode : in  OPCODE_W  opcode field of the instruction word
//   dec    : out dec_t     {st, ld, cy, acc, imm_sel, legal}
// SUB raises cy like ADD because the borrow is stored in CY.
// ---------------------------------------------------------------------------
module id_opdec
    import id_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output dec_t                dec
);

    always_comb begin
        dec       = '0;
        dec.legal = 1'b1;
        case (opcode)
            OPCODE_W'(OP_NOP): ;
            OPCODE_W'(OP_LD):  begin dec.ld = 1'b1; dec.acc = 1'b1; end
            OPCODE_W'(OP_ST):  dec.st = 1'b1;
            OPCODE_W'(OP_ADD): begin dec.cy = 1'b1; dec.acc = 1'b1; end
            OPCODE_W'(OP_SUB): begin dec.cy = 1'b1; dec.acc = 1'b1; end
            OPCODE_W'(OP_AND): dec.acc = 1'b1;
            OPCODE_W'(OP_OR):  dec.acc = 1'b1;
            OPCODE_W'(OP_XOR): dec.acc = 1'b1;
            OPCODE_W'(OP_NOT): dec.acc = 1'b1;
            OPCODE_W'(OP_LDI): begin dec.acc = 1'b1; dec.imm_sel = 1'b1; end
            default:           dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
// Registered instruction-decode stage with valid/ready handshake, flush and
// two-word LDI support (opcode word, then immediate word).
//   clk  : in  system clock, rising edge
//   rst  : in  asynchronous active-high reset
//   bus  : id_stage_if.slave
//          flush, in_valid/in_ready/in_instr (fetch side),
//          out_valid/out_ready, out_opcode, out_reg_addr, out_imm,
//          out_st_ce, out_ld_ce, out_cy_ce, out_acc_ce, out_imm_sel,
//          illegal (only with ID_ILLEGAL_TRAP_EN)
// Optional feature macro: ID_ILLEGAL_TRAP_EN -- undefined opcodes are dropped
// and raise a sticky illegal flag instead of decoding as NOP.
// ---------------------------------------------------------------------------
module id_stage
    import id_pkg::*;
#(
    parameter int INSTR_W    = DEF_INSTR_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic       clk,
    input  logic       rst,
    id_stage_if.slave  bus
);

    localparam int OPCODE_W = INSTR_W - REG_ADDR_W;

    state_t                state_reg, state_next;
    logic [OPCODE_W-1:0]   pend_opcode_reg, pend_opcode_next;
    logic [REG_ADDR_W-1:0] pend_reg_addr_reg, pend_reg_addr_next;

    logic                  out_valid_reg, out_valid_next;
    logic [OPCODE_W-1:0]   out_opcode_reg, out_opcode_next;
    logic [REG_ADDR_W-1:0] out_reg_addr_reg, out_reg_addr_next;
    logic [INSTR_W-1:0]    out_imm_reg, out_imm_next;
    logic                  st_ce_reg, st_ce_next;
    logic                  ld_ce_reg, ld_ce_next;
    logic                  cy_ce_reg, cy_ce_next;
    logic                  acc_ce_reg, acc_ce_next;
    logic                  imm_sel_reg, imm_sel_next;
`ifdef ID_ILLEGAL_TRAP_EN
    logic                  illegal_reg, illegal_next;
`endif

    logic                  in_ready;
    logic                  accept;
    logic                  consume;
    logic [OPCODE_W-1:0]   in_opcode;
    logic [REG_ADDR_W-1:0] in_reg_addr;
    dec_t                  in_dec;

    assign in_opcode   = bus.in_instr[INSTR_W-1:REG_ADDR_W];
    assign in_reg_addr = bus.in_instr[REG_ADDR_W-1:0];

    // A new word may enter only when the output slot is free or being
    // drained this cycle; flush blocks acceptance outright.
    assign in_ready = !bus.flush && (!out_valid_reg || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign consume  = out_valid_reg && bus.out_ready;

    id_opdec #(
        .OPCODE_W (OPCODE_W)
    ) u_opdec (
        .opcode (in_opcode),
        .dec    (in_dec)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (bus.flush) begin
            state_next = ST_IDLE;
        end else if (accept) begin
            case (state_reg)
                ST_IDLE:     if (in_dec.imm_sel) state_next = ST_WAIT_IMM;
                ST_WAIT_IMM: state_next = ST_IDLE;
                default:     state_next = ST_IDLE;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        out_valid_next     = out_valid_reg;
        out_opcode_next    = out_opcode_reg;
        out_reg_addr_next  = out_reg_addr_reg;
        out_imm_next       = out_imm_reg;
        st_ce_next         = st_ce_reg;
        ld_ce_next         = ld_ce_reg;
        cy_ce_next         = cy_ce_reg;
        acc_ce_next        = acc_ce_reg;
        imm_sel_next       = imm_sel_reg;
        pend_opcode_next   = pend_opcode_reg;
        pend_reg_addr_next = pend_reg_addr_reg;
`ifdef ID_ILLEGAL_TRAP_EN
        illegal_next       = illegal_reg;
`endif

        if (bus.flush || consume) begin
            // Enables are forced low together with valid so a bubble never
            // carries stale unit enables.
            out_valid_next = 1'b0;
            st_ce_next     = 1'b0;
            ld_ce_next     = 1'b0;
            cy_ce_next     = 1'b0;
            acc_ce_next    = 1'b0;
            imm_sel_next   = 1'b0;
        end

        if (accept) begin
            if (state_reg == ST_WAIT_IMM) begin
                out_valid_next    = 1'b1;
                out_opcode_next   = pend_opcode_reg;
                out_reg_addr_next = pend_reg_addr_reg;
                out_imm_next      = bus.in_instr;
                acc_ce_next       = 1'b1;
                imm_sel_next      = 1'b1;
            end else if (in_dec.imm_sel) begin
                // First LDI word: remember it, emit nothing yet.
                pend_opcode_next   = in_opcode;
                pend_reg_addr_next = in_reg_addr;
            end
`ifdef ID_ILLEGAL_TRAP_EN
            else if (!in_dec.legal) begin
                illegal_next = 1'b1;
            end
`endif
            else begin
                // Undefined opcodes (legal=0) fall through as NOP here.
                out_valid_next    = 1'b1;
                out_opcode_next   = in_opcode;
                out_reg_addr_next = in_reg_addr;
                out_imm_next      = '0;
                st_ce_next        = in_dec.st  & in_dec.legal;
                ld_ce_next        = in_dec.ld  & in_dec.legal;
                cy_ce_next        = in_dec.cy  & in_dec.legal;
                acc_ce_next       = in_dec.acc & in_dec.legal;
                imm_sel_next      = 1'b0;
            end
        end
    end

    // Output and pending-LDI registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg     <= 1'b0;
            out_opcode_reg    <= '0;
            out_reg_addr_reg  <= '0;
            out_imm_reg       <= '0;
            st_ce_reg         <= 1'b0;
            ld_ce_reg         <= 1'b0;
            cy_ce_reg         <= 1'b0;
            acc_ce_reg        <= 1'b0;
            imm_sel_reg       <= 1'b0;
            pend_opcode_reg   <= '0;
            pend_reg_addr_reg <= '0;
`ifdef ID_ILLEGAL_TRAP_EN
            illegal_reg       <= 1'b0;
`endif
        end else begin
            out_valid_reg     <= out_valid_next;
            out_opcode_reg    <= out_opcode_next;
            out_reg_addr_reg  <= out_reg_addr_next;
            out_imm_reg       <= out_imm_next;
            st_ce_reg         <= st_ce_next;
            ld_ce_reg         <= ld_ce_next;
            cy_ce_reg         <= cy_ce_next;
            acc_ce_reg        <= acc_ce_next;
            imm_sel_reg       <= imm_sel_next;
            pend_opcode_reg   <= pend_opcode_next;
            pend_reg_addr_reg <= pend_reg_addr_next;
`ifdef ID_ILLEGAL_TRAP_EN
            illegal_reg       <= illegal_next;
`endif
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_reg;
    assign bus.out_opcode   = out_opcode_reg;
    assign bus.out_reg_addr = out_reg_addr_reg;
    assign bus.out_imm      = out_imm_reg;
    assign bus.out_st_ce    = st_ce_reg;
    assign bus.out_ld_ce    = ld_ce_reg;
    assign bus.out_cy_ce    = cy_ce_reg;
    assign bus.out_acc_ce   = acc_ce_reg;
    assign bus.out_imm_sel  = imm_sel_reg;
`ifdef ID_ILLEGAL_TRAP_EN
    assign bus.illegal      = illegal_reg;
`endif

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage
// Directed bench for id_stage. Expected decode results are pushed to a
// scoreboard queue when the producing word is driven and popped by a monitor
// on every output handshake (sampled on the falling clock edge).
// ---------------------------------------------------------------------------
module tb_id_stage;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] ra;
        logic [7:0] imm;
        logic       st;
        logic       ld;
        logic       cy;
        logic       acc;
        logic       isel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   n_out    = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    id_stage_if #(.INSTR_W(8), .REG_ADDR_W(4)) bus ();

    id_stage #(.INSTR_W(8), .REG_ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic exp_t mk(input logic [3:0] op, input logic [3:0] ra,
                                input logic [7:0] imm, input logic st,
                                input logic ld, input logic cy,
                                input logic acc, input logic isel);
        exp_t e;
        e = {op, ra, imm, st, ld, cy, acc, isel};
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o = {bus.out_opcode, bus.out_reg_addr, bus.out_imm, bus.out_st_ce,
             bus.out_ld_ce, bus.out_cy_ce, bus.out_acc_ce, bus.out_imm_sel};
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present one set of inputs for one clock edge; rdy is in_ready as seen
    // with these inputs applied, before the edge.
    task automatic drive(input logic v, input logic [7:0] w, input logic ordy,
                         input logic fl, output logic rdy);
        bus.in_valid  = v;
        bus.in_instr  = w;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        rdy = bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(bus.out_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("out%0d", n_out), 32'(observed()), 32'(e));
                n_out++;
            end
        end
        if (!rst && !bus.out_valid) begin
            check("idle_enables_low", 32'({bus.out_st_ce, bus.out_ld_ce,
                  bus.out_cy_ce, bus.out_acc_ce, bus.out_imm_sel}), 32'd0);
        end
    end

    initial begin
        logic rdy;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 8'h00;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_outputs", 32'(observed()), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef ID_ILLEGAL_TRAP_EN
        check("rst_illegal", 32'(bus.illegal), 32'd0);
`endif
        rst = 1'b0;

        // ADD r3: one-cycle latency
        exp_q.push_back(mk(4'd3, 4'd3, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        drive(1'b1, 8'h33, 1'b1, 1'b0, rdy);
        check("add_in_ready", 32'(rdy), 32'd1);
        check("add_latency", 32'(bus.out_valid), 32'd1);

        // ST r1, LD r2, XOR r5 back-to-back
        exp_q.push_back(mk(4'd2, 4'd1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        drive(1'b1, 8'h21, 1'b1, 1'b0, rdy);
        check("st_in_ready", 32'(rdy), 32'd1);
        exp_q.push_back(mk(4'd1, 4'd2, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 8'h12, 1'b1, 1'b0, rdy);
        check("ld_in_ready", 32'(rdy), 32'd1);
        exp_q.push_back(mk(4'd7, 4'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 8'h75, 1'b1, 1'b0, rdy);
        check("xor_in_ready", 32'(rdy), 32'd1);

        // LDI r4, imm 0xA5: first word yields no output
        drive(1'b1, 8'h94, 1'b1, 1'b0, rdy);
        check("ldi_first_no_output", 32'(bus.out_valid), 32'd0);
        exp_q.push_back(mk(4'd9, 4'd4, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        drive(1'b1, 8'hA5, 1'b1, 1'b0, rdy);
        check("ldi_imm_valid", 32'(bus.out_valid), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0, rdy);

        // SUB r0 held under backpressure for 3 cycles
        exp_q.push_back(mk(4'd4, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        drive(1'b1, 8'h40, 1'b0, 1'b0, rdy);
        check("sub_accept", 32'(rdy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h61, 1'b0, 1'b0, rdy);
            check($sformatf("stall%0d_in_ready", i), 32'(rdy), 32'd0);
            check($sformatf("stall%0d_hold", i), 32'({bus.out_valid, observed()}),
                  32'({1'b1, mk(4'd4, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)}));
        end
        // Release: SUB drains and OR r1 enters on the same edge
        exp_q.push_back(mk(4'd6, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 8'h61, 1'b1, 1'b0, rdy);
        check("release_in_ready", 32'(rdy), 32'd1);
        check("or_opcode", 32'(bus.out_opcode), 32'd6);

        // LDI r7 then flush: the half-instruction is discarded
        drive(1'b1, 8'h97, 1'b1, 1'b0, rdy);
        drive(1'b1, 8'hAA, 1'b1, 1'b1, rdy);
        check("flush_in_ready", 32'(rdy), 32'd0);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        exp_q.push_back(mk(4'd8, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 8'h82, 1'b1, 1'b0, rdy);
        check("not_after_flush", 32'(bus.out_valid), 32'd1);

        // Undefined opcode 0xF
`ifdef ID_ILLEGAL_TRAP_EN
        drive(1'b1, 8'hF0, 1'b1, 1'b0, rdy);
        check("trap_no_output", 32'(bus.out_valid), 32'd0);
        check("trap_illegal_set", 32'(bus.illegal), 32'd1);
        exp_q.push_back(mk(4'd5, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 8'h51, 1'b1, 1'b0, rdy);
        check("trap_and_valid", 32'(bus.out_valid), 32'd1);
        check("trap_illegal_sticky", 32'(bus.illegal), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b1, rdy);
        check("trap_illegal_after_flush", 32'(bus.illegal), 32'd1);
`else
        exp_q.push_back(mk(4'hF, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        drive(1'b1, 8'hF0, 1'b1, 1'b0, rdy);
        check("undef_as_nop_valid", 32'(bus.out_valid), 32'd1);
        exp_q.push_back(mk(4'd5, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 8'h51, 1'b1, 1'b0, rdy);
        check("and_valid", 32'(bus.out_valid), 32'd1);
`endif

        // NOP r5 occupies a slot with no enables
        exp_q.push_back(mk(4'd0, 4'd5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        drive(1'b1, 8'h05, 1'b1, 1'b0, rdy);
        check("nop_valid", 32'(bus.out_valid), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0, rdy);

        // Reset mid-LDI: following word decodes as an ordinary instruction
        drive(1'b1, 8'h93, 1'b1, 1'b0, rdy);
        check("ldi2_no_output", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #2;
        check("midldi_rst_out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        exp_q.push_back(mk(4'd2, 4'd1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        drive(1'b1, 8'h21, 1'b1, 1'b0, rdy);
        check("post_rst_st_valid", 32'(bus.out_valid), 32'd1);

        // Drain
        drive(1'b0, 8'h00, 1'b1, 1'b0, rdy);
        drive(1'b0, 8'h00, 1'b1, 1'b0, rdy);
        check("final_out_valid", 32'(bus.out_valid), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
